// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR scrub monitor.
package tmr_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      SCRUB   = 2'd2
   } state_e;

   localparam logic [1:0] FAULT_NONE = 2'd3;

   function automatic logic [2:0] onehot3(input logic [1:0] idx);
      onehot3 = 3'b001 << idx;
   endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// Bitwise 2-of-3 majority vote plus per-replica mismatch mask against the vote.
module tmr_majority_voter #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] rep0,
   input  logic [WIDTH-1:0] rep1,
   input  logic [WIDTH-1:0] rep2,
   output logic [WIDTH-1:0] maj,
   output logic [2:0]       mism
);

   assign maj     = (rep0 & rep1) | (rep0 & rep2) | (rep1 & rep2);
   assign mism[0] = (rep0 != maj);
   assign mism[1] = (rep1 != maj);
   assign mism[2] = (rep2 != maj);

endmodule

// File: rtl/tmr_scrub_monitor.sv
// TMR read-side monitor: votes replicas, confirms a single faulty replica and scrubs it via req/ack.
// Optional ack timeout is built when TMR_SCRUB_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | no fault under observation
// CONFIRM | single-replica mismatch seen, counting consecutive confirmations
// SCRUB   | scrub_req high, waiting for scrub_ack (or timeout)
module tmr_scrub_monitor
   import tmr_pkg::*;
#(
   parameter int WIDTH          = 4,
   parameter int CONFIRM_CYCLES = 2,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] rep0_data,
   input  logic [WIDTH-1:0] rep1_data,
   input  logic [WIDTH-1:0] rep2_data,
   input  logic             clear_status,
   input  logic             scrub_ack,
   output logic [WIDTH-1:0] voted_data,
   output logic             scrub_req,
   output logic [2:0]       scrub_sel,
   output logic [WIDTH-1:0] scrub_data,
   output logic [1:0]       fault_id,
   output logic [CNT_W-1:0] err_count,
   output logic             multi_fault,
   output logic             timeout_flag
);

   localparam int CW = $clog2(CONFIRM_CYCLES + 1);

   logic [WIDTH-1:0] maj;
   logic [2:0]       mism;
   logic             single;
   logic             multi;
   logic [1:0]       fault_idx;

   state_e           state, state_n;
   logic [CW-1:0]    cnt, cnt_n, cnt_inc;
   logic [1:0]       cand, cand_n;
   logic             enter_scrub;
   logic             scrub_done;
   logic             scrub_drop;
   logic             timeout_hit;
   logic [CNT_W-1:0] err_base, err_n;

   tmr_majority_voter #(.WIDTH(WIDTH)) u_voter (
      .rep0 (rep0_data),
      .rep1 (rep1_data),
      .rep2 (rep2_data),
      .maj  (maj),
      .mism (mism)
   );

   always_comb begin
      single    = (mism == 3'b001) || (mism == 3'b010) || (mism == 3'b100);
      multi     = (mism[0] & mism[1]) | (mism[0] & mism[2]) | (mism[1] & mism[2]);
      fault_idx = mism[0] ? 2'd0 : (mism[1] ? 2'd1 : 2'd2);
      cnt_inc   = cnt + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         cand  <= cand_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      cand_n      = cand;
      enter_scrub = 1'b0;
      scrub_done  = 1'b0;
      scrub_drop  = 1'b0;
      case (state)
         IDLE: begin
            if (enable && single) begin
               cand_n = fault_idx;
               if (CONFIRM_CYCLES == 1) begin
                  state_n     = SCRUB;
                  enter_scrub = 1'b1;
                  cnt_n       = '0;
               end else begin
                  state_n = CONFIRM;
                  cnt_n   = CW'(1);
               end
            end
         end
         CONFIRM: begin
            if (!enable || !single) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (fault_idx != cand) begin
               cand_n = fault_idx;
               cnt_n  = CW'(1);
            end else if (cnt_inc == CW'(CONFIRM_CYCLES)) begin
               state_n     = SCRUB;
               enter_scrub = 1'b1;
               cnt_n       = '0;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         SCRUB: begin
            // Ack wins over a timeout expiring in the same cycle.
            if (scrub_ack) begin
               state_n    = IDLE;
               scrub_done = 1'b1;
            end else if (timeout_hit) begin
               state_n    = IDLE;
               scrub_drop = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Clear first, then apply the same-cycle increment so the new event survives.
   always_comb begin
      err_base = clear_status ? '0 : err_count;
      err_n    = err_base;
      if (scrub_done && (err_base != {CNT_W{1'b1}}))
         err_n = err_base + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         voted_data  <= '0;
         scrub_req   <= 1'b0;
         scrub_sel   <= '0;
         scrub_data  <= '0;
         fault_id    <= FAULT_NONE;
         err_count   <= '0;
         multi_fault <= 1'b0;
      end else begin
         voted_data  <= maj;
         err_count   <= err_n;
         multi_fault <= (multi_fault && !clear_status) || (multi && enable);
         if (enter_scrub) begin
            scrub_req  <= 1'b1;
            scrub_sel  <= onehot3(fault_idx);
            scrub_data <= maj;
            fault_id   <= fault_idx;
         end else if (scrub_done || scrub_drop) begin
            scrub_req <= 1'b0;
         end
      end
   end

`ifdef TMR_SCRUB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tmr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr          <= '0;
         timeout_flag <= 1'b0;
      end else begin
         timeout_flag <= (timeout_flag && !clear_status) || scrub_drop;
         if (enter_scrub)
            tmr <= TW'(TIMEOUT_CYCLES);
         else if ((state == SCRUB) && (tmr != '0))
            tmr <= tmr - TW'(1);
      end
   end

   assign timeout_hit = (state == SCRUB) && (tmr == TW'(1));
`else
   logic unused_timeout;

   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign timeout_hit    = 1'b0;
   assign timeout_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_tmr_scrub_monitor.sv
// Directed-vector bench for tmr_scrub_monitor (WIDTH=4, CONFIRM_CYCLES=2, CNT_W=8).
module tb_tmr_scrub_monitor;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] rep0_data, rep1_data, rep2_data;
   logic       clear_status;
   logic       scrub_ack;
   logic [3:0] voted_data;
   logic       scrub_req;
   logic [2:0] scrub_sel;
   logic [3:0] scrub_data;
   logic [1:0] fault_id;
   logic [7:0] err_count;
   logic       multi_fault;
   logic       timeout_flag;

   int n_cmp = 0;
   int n_bad = 0;

   tmr_scrub_monitor #(
      .WIDTH(4), .CONFIRM_CYCLES(2), .CNT_W(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .rep0_data    (rep0_data),
      .rep1_data    (rep1_data),
      .rep2_data    (rep2_data),
      .clear_status (clear_status),
      .scrub_ack    (scrub_ack),
      .voted_data   (voted_data),
      .scrub_req    (scrub_req),
      .scrub_sel    (scrub_sel),
      .scrub_data   (scrub_data),
      .fault_id     (fault_id),
      .err_count    (err_count),
      .multi_fault  (multi_fault),
      .timeout_flag (timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [3:0] r0, r1, r2;
      logic       clr, ack;
      logic [3:0] ev;
      logic       ereq;
      logic [2:0] esel;
      logic [3:0] edata;
      logic [1:0] efid;
      logic [7:0] eerr;
      logic       emulti;
   } vec_t;

   vec_t tv[29];

   function automatic vec_t mk(logic en, logic [3:0] r0, logic [3:0] r1, logic [3:0] r2,
                               logic clr, logic ack, logic [3:0] ev, logic ereq,
                               logic [2:0] esel, logic [3:0] edata, logic [1:0] efid,
                               logic [7:0] eerr, logic emulti);
      vec_t v;
      v.en = en; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.clr = clr; v.ack = ack;
      v.ev = ev; v.ereq = ereq; v.esel = esel; v.edata = edata; v.efid = efid;
      v.eerr = eerr; v.emulti = emulti;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [3:0] r0, input logic [3:0] r1,
                        input logic [3:0] r2, input logic clr, input logic ack);
      enable = en; rep0_data = r0; rep1_data = r1; rep2_data = r2;
      clear_status = clr; scrub_ack = ack;
   endtask

   initial begin
      // en r0 r1 r2 clr ack | voted req sel data fid err multi
      tv[0]  = mk(1, 4'h0, 4'h0, 4'h0, 0, 0, 4'h0, 0, 3'b000, 4'h0, 2'd3, 8'd0, 0);
      tv[1]  = mk(1, 4'hA, 4'hA, 4'hA, 0, 0, 4'hA, 0, 3'b000, 4'h0, 2'd3, 8'd0, 0);
      tv[2]  = mk(1, 4'h6, 4'h6, 4'h7, 0, 0, 4'h6, 0, 3'b000, 4'h0, 2'd3, 8'd0, 0);
      tv[3]  = mk(1, 4'h6, 4'h6, 4'h7, 0, 0, 4'h6, 1, 3'b100, 4'h6, 2'd2, 8'd0, 0);
      tv[4]  = mk(1, 4'h6, 4'h6, 4'h7, 0, 0, 4'h6, 1, 3'b100, 4'h6, 2'd2, 8'd0, 0);
      tv[5]  = mk(1, 4'h6, 4'h6, 4'h6, 0, 0, 4'h6, 1, 3'b100, 4'h6, 2'd2, 8'd0, 0);
      tv[6]  = mk(1, 4'h6, 4'h6, 4'h6, 0, 1, 4'h6, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[7]  = mk(1, 4'h6, 4'h6, 4'h6, 0, 1, 4'h6, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[8]  = mk(1, 4'h6, 4'hF, 4'h6, 0, 0, 4'h6, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[9]  = mk(1, 4'h6, 4'h6, 4'h6, 0, 0, 4'h6, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[10] = mk(1, 4'h6, 4'h6, 4'h6, 0, 0, 4'h6, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[11] = mk(1, 4'h1, 4'h2, 4'h0, 0, 0, 4'h0, 0, 3'b000, 4'h0, 2'd2, 8'd1, 1);
      tv[12] = mk(1, 4'h1, 4'h2, 4'h0, 0, 0, 4'h0, 0, 3'b000, 4'h0, 2'd2, 8'd1, 1);
      tv[13] = mk(1, 4'h0, 4'h0, 4'h0, 1, 0, 4'h0, 0, 3'b000, 4'h0, 2'd2, 8'd0, 0);
      tv[14] = mk(1, 4'h5, 4'h4, 4'h5, 0, 0, 4'h5, 0, 3'b000, 4'h0, 2'd2, 8'd0, 0);
      tv[15] = mk(0, 4'h5, 4'h4, 4'h5, 0, 0, 4'h5, 0, 3'b000, 4'h0, 2'd2, 8'd0, 0);
      tv[16] = mk(0, 4'h5, 4'h4, 4'h5, 0, 0, 4'h5, 0, 3'b000, 4'h0, 2'd2, 8'd0, 0);
      tv[17] = mk(1, 4'h5, 4'h4, 4'h5, 0, 0, 4'h5, 0, 3'b000, 4'h0, 2'd2, 8'd0, 0);
      tv[18] = mk(1, 4'h5, 4'h4, 4'h5, 0, 0, 4'h5, 1, 3'b010, 4'h5, 2'd1, 8'd0, 0);
      tv[19] = mk(0, 4'h5, 4'h5, 4'h5, 0, 0, 4'h5, 1, 3'b010, 4'h5, 2'd1, 8'd0, 0);
      tv[20] = mk(0, 4'h5, 4'h5, 4'h5, 0, 1, 4'h5, 0, 3'b000, 4'h0, 2'd1, 8'd1, 0);
      tv[21] = mk(1, 4'h3, 4'h3, 4'h2, 0, 0, 4'h3, 0, 3'b000, 4'h0, 2'd1, 8'd1, 0);
      tv[22] = mk(1, 4'h3, 4'h3, 4'h2, 0, 0, 4'h3, 1, 3'b100, 4'h3, 2'd2, 8'd1, 0);
      tv[23] = mk(1, 4'h1, 4'h2, 4'h0, 0, 0, 4'h0, 1, 3'b100, 4'h3, 2'd2, 8'd1, 1);
      tv[24] = mk(1, 4'h3, 4'h3, 4'h3, 1, 1, 4'h3, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[25] = mk(1, 4'h3, 4'h3, 4'h2, 0, 0, 4'h3, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[26] = mk(1, 4'h2, 4'h3, 4'h3, 0, 0, 4'h3, 0, 3'b000, 4'h0, 2'd2, 8'd1, 0);
      tv[27] = mk(1, 4'h2, 4'h3, 4'h3, 0, 0, 4'h3, 1, 3'b001, 4'h3, 2'd0, 8'd1, 0);
      tv[28] = mk(1, 4'h3, 4'h3, 4'h3, 0, 1, 4'h3, 0, 3'b000, 4'h0, 2'd0, 8'd2, 0);

      rst = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      #12;
      chk("rst_voted", -1, 32'(voted_data), 32'h0);
      chk("rst_req",   -1, 32'(scrub_req),  32'h0);
      chk("rst_sel",   -1, 32'(scrub_sel),  32'h0);
      chk("rst_data",  -1, 32'(scrub_data), 32'h0);
      chk("rst_fid",   -1, 32'(fault_id),   32'h3);
      chk("rst_err",   -1, 32'(err_count),  32'h0);
      chk("rst_multi", -1, 32'(multi_fault), 32'h0);
      chk("rst_tmo",   -1, 32'(timeout_flag), 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 29; i++) begin
         drive(tv[i].en, tv[i].r0, tv[i].r1, tv[i].r2, tv[i].clr, tv[i].ack);
         tick();
         chk("voted", i, 32'(voted_data),  32'(tv[i].ev));
         chk("req",   i, 32'(scrub_req),   32'(tv[i].ereq));
         chk("fid",   i, 32'(fault_id),    32'(tv[i].efid));
         chk("err",   i, 32'(err_count),   32'(tv[i].eerr));
         chk("multi", i, 32'(multi_fault), 32'(tv[i].emulti));
         if (tv[i].ereq) begin
            chk("sel",  i, 32'(scrub_sel),  32'(tv[i].esel));
            chk("data", i, 32'(scrub_data), 32'(tv[i].edata));
         end
      end

      // Ack withheld: timeout build drops req after 16 cycles, default build holds it.
      drive(1'b1, 4'h6, 4'h6, 4'h7, 1'b0, 1'b0);
      tick();
      tick();
      chk("tmo_req_rise", 100, 32'(scrub_req), 32'h1);
      drive(1'b1, 4'h6, 4'h6, 4'h6, 1'b0, 1'b0);
      for (int k = 0; k < 15; k++) tick();
      chk("tmo_req_15", 101, 32'(scrub_req), 32'h1);
      tick();
`ifdef TMR_SCRUB_TIMEOUT_EN
      chk("tmo_req_16",  102, 32'(scrub_req),    32'h0);
      chk("tmo_flag",    102, 32'(timeout_flag), 32'h1);
      chk("tmo_err",     102, 32'(err_count),    32'd2);
`else
      for (int k = 0; k < 24; k++) tick();
      chk("hold_req_40", 102, 32'(scrub_req),    32'h1);
      chk("hold_flag",   102, 32'(timeout_flag), 32'h0);
      drive(1'b1, 4'h6, 4'h6, 4'h6, 1'b0, 1'b1);
      tick();
      chk("hold_ack_req", 103, 32'(scrub_req), 32'h0);
      chk("hold_ack_err", 103, 32'(err_count), 32'd3);
`endif

      // Saturation of err_count.
      drive(1'b1, 4'h6, 4'h6, 4'h6, 1'b1, 1'b0);
      tick();
      chk("clr_err", 104, 32'(err_count),    32'd0);
      chk("clr_tmo", 104, 32'(timeout_flag), 32'h0);
      for (int s = 0; s < 256; s++) begin
         drive(1'b1, 4'h6, 4'h6, 4'h7, 1'b0, 1'b0);
         tick();
         tick();
         drive(1'b1, 4'h6, 4'h6, 4'h6, 1'b0, 1'b1);
         tick();
         if (s == 253) chk("sat_254", 105, 32'(err_count), 32'd254);
         if (s == 254) chk("sat_255", 106, 32'(err_count), 32'd255);
      end
      chk("sat_hold", 107, 32'(err_count), 32'd255);

      // Reset in the middle of a scrub handshake.
      drive(1'b1, 4'h6, 4'h6, 4'h7, 1'b0, 1'b0);
      tick();
      tick();
      chk("mid_req", 108, 32'(scrub_req), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_req", 109, 32'(scrub_req),  32'h0);
      chk("arst_fid", 109, 32'(fault_id),   32'h3);
      chk("arst_err", 109, 32'(err_count),  32'h0);
      chk("arst_vot", 109, 32'(voted_data), 32'h0);
      drive(1'b1, 4'h6, 4'h6, 4'h6, 1'b0, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_req", 110, 32'(scrub_req), 32'h0);
      chk("post_rst_err", 110, 32'(err_count), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
